// File: rtl/stair_pkg.sv
// stair_pkg: shared state codes, colours and default geometry for the stair scheduler
package stair_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_START_WAIT = 3'd1;
  localparam state_t S_DRAW_ALL   = 3'd2;
  localparam state_t S_WAIT_FRAME = 3'd3;
  localparam state_t S_ERASE_ALL  = 3'd4;
  localparam state_t S_MOVE       = 3'd5;
  localparam logic [2:0] COLOUR_STAIR = 3'b100;
  localparam logic [2:0] COLOUR_BG    = 3'b000;
  localparam int DEF_STAIR_W = 40;
  localparam int DEF_STAIR_H = 5;
  localparam int DEF_Y_WRAP  = 116;
endpackage

// File: rtl/stair_frame_scheduler_rect_raster.sv
// rect_raster: walks a STAIR_W x STAIR_H rectangle one pixel per cycle, dx fastest
module rect_raster #(
  parameter int STAIR_W = 40,
  parameter int STAIR_H = 5,
  localparam int DXW = STAIR_W > 1 ? $clog2(STAIR_W) : 1,
  localparam int DYW = STAIR_H > 1 ? $clog2(STAIR_H) : 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           run,
  output logic [DXW-1:0] dx,
  output logic [DYW-1:0] dy,
  output logic           last
);
  logic dx_end;
  assign dx_end = dx == DXW'(STAIR_W - 1);
  assign last   = dx_end && dy == DYW'(STAIR_H - 1);
  always_ff @(posedge clock) begin
    if (!reset_n || !run || last) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= dx_end ? '0 : dx + 1'b1;
      dy <= dx_end ? dy + 1'b1 : dy;
    end
  end
endmodule

// File: rtl/stair_frame_scheduler.sv
// stair_frame_scheduler: draw/wait/erase/move sequencer sharing one VGA plot port among stairs.
// Define STAIR_PAUSE_EN to add a pause input that freezes frame timing in WAIT_FRAME.
module stair_frame_scheduler
  import stair_pkg::*;
#(
  parameter int NUM_STAIRS      = 4,
  parameter int STAIR_W         = DEF_STAIR_W,
  parameter int STAIR_H         = DEF_STAIR_H,
  parameter int FRAME_TICKS     = 833334,
  parameter int FRAMES_PER_STEP = 15,
  parameter int Y_WRAP          = DEF_Y_WRAP
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    go,
`ifdef STAIR_PAUSE_EN
  input  logic                    pause,
`endif
  input  logic [8*NUM_STAIRS-1:0] init_x,
  input  logic [7*NUM_STAIRS-1:0] init_y,
  output logic [7:0]              x,
  output logic [6:0]              y,
  output logic [2:0]              colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    step_done,
  output logic [2:0]              state
);
  localparam int IW  = NUM_STAIRS > 1 ? $clog2(NUM_STAIRS) : 1;
  localparam int TW  = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  localparam int FW  = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int DXW = STAIR_W > 1 ? $clog2(STAIR_W) : 1;
  localparam int DYW = STAIR_H > 1 ? $clog2(STAIR_H) : 1;
  state_t         nxt;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  tick;
  logic [FW-1:0]  frame;
  logic [7:0]     pos_x [NUM_STAIRS];
  logic [6:0]     pos_y [NUM_STAIRS];
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic           last, last_idx, drawing, advance, tick_wrap, frame_done;
  assign drawing  = state == S_DRAW_ALL || state == S_ERASE_ALL;
  assign last_idx = idx == IW'(NUM_STAIRS - 1);
`ifdef STAIR_PAUSE_EN
  assign advance = state == S_WAIT_FRAME && !pause;
`else
  assign advance = state == S_WAIT_FRAME;
`endif
  assign tick_wrap  = advance && tick == TW'(FRAME_TICKS - 1);
  assign frame_done = tick_wrap && frame == FW'(FRAMES_PER_STEP - 1);
  rect_raster #(.STAIR_W(STAIR_W), .STAIR_H(STAIR_H)) u_raster (
    .clock  (clock),
    .reset_n(reset_n),
    .run    (drawing),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:       nxt = go ? S_START_WAIT : S_IDLE;
      S_START_WAIT: nxt = go ? S_START_WAIT : S_DRAW_ALL;
      S_DRAW_ALL:   nxt = last && last_idx ? S_WAIT_FRAME : S_DRAW_ALL;
      S_WAIT_FRAME: nxt = frame_done ? S_ERASE_ALL : S_WAIT_FRAME;
      S_ERASE_ALL:  nxt = last && last_idx ? S_MOVE : S_ERASE_ALL;
      S_MOVE:       nxt = S_DRAW_ALL;
      default:      nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= nxt;
      if (drawing && last) idx <= last_idx ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n || state != S_WAIT_FRAME) begin
      tick  <= '0;
      frame <= '0;
    end else if (advance) begin
      tick  <= tick_wrap ? '0 : tick + 1'b1;
      frame <= frame_done ? '0 : tick_wrap ? frame + 1'b1 : frame;
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_STAIRS; i++) begin
      if (!reset_n) begin
        pos_x[i] <= init_x[8*i +: 8];
        pos_y[i] <= init_y[7*i +: 7];
      end else if (state == S_MOVE) begin
        pos_y[i] <= pos_y[i] == '0 ? 7'(Y_WRAP) : pos_y[i] - 1'b1;
      end
    end
  end
  assign plot      = drawing;
  assign x         = drawing ? 8'(pos_x[idx] + 8'(dx)) : '0;
  assign y         = drawing ? 7'(pos_y[idx] + 7'(dy)) : '0;
  assign colour    = state == S_DRAW_ALL ? COLOUR_STAIR : COLOUR_BG;
  assign busy      = state != S_IDLE && state != S_START_WAIT;
  assign step_done = state == S_MOVE;
endmodule

// File: tb/tb_stair_frame_scheduler.sv
// tb_stair_frame_scheduler: scoreboard bench for the stair scheduler on a small geometry
module tb_stair_frame_scheduler;
  localparam int NS = 2, W = 4, H = 2, FT = 4, FPS = 2, NPIX = NS * W * H;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;
  logic clock = 1'b0, reset_n = 1'b0, go = 1'b0;
  logic [8*NS-1:0] init_x = '0;
  logic [7*NS-1:0] init_y = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour, state;
  logic plot, busy, step_done;
`ifdef STAIR_PAUSE_EN
  logic pause = 1'b0;
  int pause_n = 0;
`endif
  int n_cmp = 0, n_err = 0;
  px_t exp_q[$];
  logic [7:0] mx [NS];
  logic [6:0] my [NS];
  always #5 clock = ~clock;
  stair_frame_scheduler #(
    .NUM_STAIRS(NS), .STAIR_W(W), .STAIR_H(H),
    .FRAME_TICKS(FT), .FRAMES_PER_STEP(FPS), .Y_WRAP(116)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .go       (go),
`ifdef STAIR_PAUSE_EN
    .pause    (pause),
`endif
    .init_x   (init_x),
    .init_y   (init_y),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .step_done(step_done),
    .state    (state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] x1, input logic [6:0] y1);
    init_x = {x1, x0};
    init_y = {y1, y0};
    mx[0] = x0; my[0] = y0; mx[1] = x1; my[1] = y1;
    reset_n = 1'b0;
    go = 1'b0;
    repeat (2) @(negedge clock);
    check("reset", {state, plot, busy, step_done, x, y, colour}, '0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle", {state, plot, busy}, '0);
  endtask
  task automatic start(input int hold);
    go = 1'b1;
    repeat (hold) begin
      @(negedge clock);
      check("start_wait", {state, plot, busy}, {3'd1, 1'b0, 1'b0});
    end
    go = 1'b0;
    @(negedge clock);
  endtask
  task automatic draw_phase(input logic [2:0] c, input int n);
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < H; j++)
        for (int i = 0; i < W; i++)
          exp_q.push_back('{x: 8'(mx[s] + 8'(i)), y: 7'(my[s] + 7'(j)), c: c});
    for (int k = 0; k < n; k++) begin
      px_t e;
      e = exp_q.pop_front();
      check("plot", {31'd0, plot}, 1);
      check("pixel", {14'd0, x, y, colour}, {14'd0, e.x, e.y, e.c});
      if (k < n - 1) @(negedge clock);
    end
    if (n == NPIX) @(negedge clock);
  endtask
  task automatic gap_phase(input int len);
    for (int k = 0; k < len; k++) begin
`ifdef STAIR_PAUSE_EN
      pause = k < pause_n;
`endif
      check("wait", {plot, busy, state}, {1'b0, 1'b1, 3'd3});
      @(negedge clock);
    end
`ifdef STAIR_PAUSE_EN
    pause = 1'b0;
`endif
  endtask
  task automatic move_phase();
    check("move", {plot, step_done, busy, state}, {1'b0, 1'b1, 1'b1, 3'd5});
    for (int s = 0; s < NS; s++) my[s] = my[s] == 0 ? 7'd116 : my[s] - 7'd1;
    @(negedge clock);
  endtask
  initial begin
    do_reset(8'd10, 7'd20, 8'd50, 7'd30);
    start(10);
    draw_phase(3'b100, NPIX);
    gap_phase(FT * FPS);
    draw_phase(3'b000, NPIX);
    move_phase();
    draw_phase(3'b100, 5);
    check("queue_partial", exp_q.size(), NPIX - 5);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("abort", {state, plot, busy, step_done}, '0);
    do_reset(8'd10, 7'd0, 8'd50, 7'd30);
    start(1);
    draw_phase(3'b100, NPIX);
`ifdef STAIR_PAUSE_EN
    pause_n = 20;
    gap_phase(FT * FPS + 20);
`else
    gap_phase(FT * FPS);
`endif
    draw_phase(3'b000, NPIX);
    move_phase();
    draw_phase(3'b100, NPIX);
    check("queue_empty", exp_q.size(), 0);
    check("after_redraw", {plot, state}, {1'b0, 3'd3});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
